// File: rtl/i2s_audio_tx_if.sv
// ---------------------------------------------------------------------------
// i2s_audio_tx_if
// Sample-pair stream from the audio mixer into the I2S transmitter.
//   left_in      : left-channel PCM sample (signed two's complement)
//   right_in     : right-channel PCM sample (signed two's complement)
//   sample_valid : left_in/right_in hold a new pair (mixer -> transmitter)
//   sample_ready : transmitter holding register is empty (transmitter -> mixer)
// A pair moves when sample_valid && sample_ready at a rising clk edge.
// ---------------------------------------------------------------------------
interface i2s_audio_tx_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] left_in;
  logic [SAMPLE_W-1:0] right_in;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output left_in,
    output right_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_in,
    input  right_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_audio_tx.sv
// ---------------------------------------------------------------------------
// i2s_audio_tx
// Serialises stereo PCM pairs into Philips-format I2S on the board pins.
//   clk       : system clock
//   reset_n   : asynchronous, active-low reset
//   audio     : sample-pair stream (slave side), single-entry holding register
//   i2s_bck   : bit clock, clk/(2*CLK_DIV)
//   i2s_lrck  : word select, 0 = left slot, 1 = right slot
//   i2s_data  : serial data, MSB first, one BCK after the word-select edge
//   underrun  : one-clk pulse when a frame starts with no new pair pending
// All serial outputs change only in the clk cycle where BCK falls, so the
// receiver can sample safely on BCK rising edges.
// ---------------------------------------------------------------------------
module i2s_audio_tx #(
  parameter int CLK_DIV  = 8,
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  i2s_audio_tx_if.slave audio,
  output logic          i2s_bck,
  output logic          i2s_lrck,
  output logic          i2s_data,
  output logic          underrun
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int SLOT_IDX_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);

  // Registered state
  logic [DIV_W-1:0]    div_cnt_reg;
  logic                bck_reg;
  logic                lrck_reg;
  logic                data_reg;
  logic                underrun_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic                pend_full_reg;
  logic [SAMPLE_W-1:0] pend_l_reg;
  logic [SAMPLE_W-1:0] pend_r_reg;
  logic [SAMPLE_W-1:0] cur_l_reg;
  logic [SAMPLE_W-1:0] cur_r_reg;

  // Next-state / decode
  logic                div_wrap;
  logic                fall_tick;
  logic                frame_start;
  logic                load_pair;
  logic                accept;
  logic [BIT_W-1:0]    bit_cnt_next;
  logic                lrck_next;
  logic [SLOT_IDX_W-1:0] slot_idx;
  logic [SAMPLE_W-1:0] cur_l_next;
  logic [SAMPLE_W-1:0] cur_r_next;
  logic [SLOT_W-1:0]   slot_l_bits;
  logic [SLOT_W-1:0]   slot_r_bits;
  logic                data_next;

  assign div_wrap     = (div_cnt_reg == DIV_LAST);
  // BCK is about to go 1->0: the only cycle in which frame state advances.
  assign fall_tick    = div_wrap && bck_reg;
  assign bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
  assign frame_start  = fall_tick && (bit_cnt_reg == BIT_LAST);
  assign load_pair    = frame_start && pend_full_reg;
  // Ready is simply "holding register empty", so a load and an accept can
  // never coincide: accept needs pend_full=0, load needs pend_full=1.
  assign accept       = audio.sample_valid && !pend_full_reg;

  assign lrck_next  = (bit_cnt_next >= SLOT_LEN);
  assign slot_idx   = SLOT_IDX_W'(lrck_next ? bit_cnt_next - SLOT_LEN : bit_cnt_next);
  assign cur_l_next = load_pair ? pend_l_reg : cur_l_reg;
  assign cur_r_next = load_pair ? pend_r_reg : cur_r_reg;

  // Per-slot bit maps: position 0 is the one-BCK I2S delay, positions
  // 1..SAMPLE_W carry the sample MSB first, the rest of the slot pads with 0.
  generate
    for (genvar gi = 0; gi < SLOT_W; gi++) begin : g_slot
      if (gi >= 1 && gi <= SAMPLE_W) begin : g_sample
        assign slot_l_bits[gi] = cur_l_next[SAMPLE_W-gi];
        assign slot_r_bits[gi] = cur_r_next[SAMPLE_W-gi];
      end else begin : g_pad
        assign slot_l_bits[gi] = 1'b0;
        assign slot_r_bits[gi] = 1'b0;
      end
    end
  endgenerate

  assign data_next = lrck_next ? slot_r_bits[slot_idx] : slot_l_bits[slot_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg   <= '0;
      bck_reg       <= 1'b0;
      lrck_reg      <= 1'b0;
      data_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
      bit_cnt_reg   <= BIT_LAST;
      pend_full_reg <= 1'b0;
      pend_l_reg    <= '0;
      pend_r_reg    <= '0;
      cur_l_reg     <= '0;
      cur_r_reg     <= '0;
    end else begin
      div_cnt_reg  <= div_wrap ? '0 : div_cnt_reg + 1'b1;
      if (div_wrap) begin
        bck_reg <= !bck_reg;
      end

      underrun_reg <= frame_start && !pend_full_reg;

      if (fall_tick) begin
        bit_cnt_reg <= bit_cnt_next;
        lrck_reg    <= lrck_next;
        data_reg    <= data_next;
        cur_l_reg   <= cur_l_next;
        cur_r_reg   <= cur_r_next;
      end

      if (load_pair) begin
        pend_full_reg <= 1'b0;
      end else if (accept) begin
        pend_l_reg    <= audio.left_in;
        pend_r_reg    <= audio.right_in;
        pend_full_reg <= 1'b1;
      end
    end
  end

  assign audio.sample_ready = !pend_full_reg;
  assign i2s_bck            = bck_reg;
  assign i2s_lrck           = lrck_reg;
  assign i2s_data           = data_reg;
  assign underrun           = underrun_reg;

endmodule
